// File: rtl/alu_share_arbiter.sv
// Round-robin share of one 32-bit ALU between two issue slots.
// The winning op drives the ALU operand and control lines combinationally. The
// ALU result is captured in a one-entry, tagged output register. Saturating
// counters record grants and contention.
module alu_share_arbiter #(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  // slot 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_ctrl,
  input  logic [TAG_W-1:0] req0_tag,
  // slot 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_ctrl,
  input  logic [TAG_W-1:0] req1_tag,
  // shared ALU
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  // result entry
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_result,
  output logic             res_zero,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_src,
  // performance counters
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic             res_valid_q;
  logic [31:0]      res_result_q;
  logic             res_zero_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             res_src_q;
  logic             prio_q;
  logic [CNT_W-1:0] grant_cnt0_q;
  logic [CNT_W-1:0] grant_cnt1_q;
  logic [CNT_W-1:0] conflict_cnt_q;

  logic             can_acc;
  logic             gnt0;
  logic             gnt1;
  logic             acc;
  logic             winner;
  logic             both_valid;
  logic [TAG_W-1:0] win_tag;

  // Grant selection, handshake and ALU operand steering.
  always_comb begin
    can_acc    = !flush && (!res_valid_q || res_ready);
    both_valid = req0_valid && req1_valid;
    // A lone valid slot wins outright; under contention prio decides.
    gnt0       = req0_valid && (!req1_valid || !prio_q);
    gnt1       = req1_valid && (!req0_valid || prio_q);
    req0_ready = can_acc && gnt0;
    req1_ready = can_acc && gnt1;
    acc        = req0_ready || req1_ready;
    winner     = req1_ready;
    // With no grant the ALU sees slot 0, which is harmless since nothing loads.
    alu_a      = gnt1 ? req1_a    : req0_a;
    alu_b      = gnt1 ? req1_b    : req0_b;
    alu_ctrl   = gnt1 ? req1_ctrl : req0_ctrl;
    win_tag    = gnt1 ? req1_tag  : req0_tag;
  end

  // Output entry: flush kills it; an accept loads it even while it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q  <= 1'b0;
      res_result_q <= '0;
      res_zero_q   <= 1'b0;
      res_tag_q    <= '0;
      res_src_q    <= 1'b0;
    end else if (flush) begin
      res_valid_q <= 1'b0;
    end else if (acc) begin
      res_valid_q  <= 1'b1;
      res_result_q <= alu_result;
      res_zero_q   <= alu_zero;
      res_tag_q    <= win_tag;
      res_src_q    <= winner;
    end else if (res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  // Round-robin pointer: the loser of the last accept goes first next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (acc) begin
      prio_q <= ~winner;
    end
  end

  // Saturating performance counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0_q   <= '0;
      grant_cnt1_q   <= '0;
      conflict_cnt_q <= '0;
    end else if (clr_cnt) begin
      grant_cnt0_q   <= '0;
      grant_cnt1_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (req0_ready && (grant_cnt0_q != '1)) begin
        grant_cnt0_q <= grant_cnt0_q + CNT_W'(1);
      end
      if (req1_ready && (grant_cnt1_q != '1)) begin
        grant_cnt1_q <= grant_cnt1_q + CNT_W'(1);
      end
      if (both_valid && can_acc && (conflict_cnt_q != '1)) begin
        conflict_cnt_q <= conflict_cnt_q + CNT_W'(1);
      end
    end
  end

  // Register outputs.
  always_comb begin
    res_valid    = res_valid_q;
    res_result   = res_result_q;
    res_zero     = res_zero_q;
    res_tag      = res_tag_q;
    res_src      = res_src_q;
    grant_cnt0   = grant_cnt0_q;
    grant_cnt1   = grant_cnt1_q;
    conflict_cnt = conflict_cnt_q;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU model.
module tb_alu_share_arbiter;

  localparam int unsigned TAG_W = 5;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_ctrl, req1_ctrl;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic [31:0]      alu_a, alu_b;
  logic [3:0]       alu_ctrl;
  logic [31:0]      alu_result;
  logic             alu_zero;
  logic             res_valid, res_ready;
  logic [31:0]      res_result;
  logic             res_zero;
  logic [TAG_W-1:0] res_tag;
  logic             res_src;
  logic             clr_cnt;
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1, conflict_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  alu_share_arbiter #(
    .TAG_W(TAG_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ctrl   (req0_ctrl),
    .req0_tag    (req0_tag),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ctrl   (req1_ctrl),
    .req1_tag    (req1_tag),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_result  (res_result),
    .res_zero    (res_zero),
    .res_tag     (res_tag),
    .res_src     (res_src),
    .clr_cnt     (clr_cnt),
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor.
  always_comb begin
    alu_result = 32'd0;
    unique case (alu_ctrl)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = alu_a ^ alu_b;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    clr_cnt    = 1'b0;
    res_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = 32'd5;  req0_b = 32'd3; req0_ctrl = 4'd1; req0_tag = 5'd7;
    req1_a = 32'd20; req1_b = 32'd4; req1_ctrl = 4'd1; req1_tag = 5'd2;
    #12;
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_res_result", res_result, 32'd0);
    check_eq("rst_grant_cnt0", 32'(grant_cnt0), 32'd0);
    check_eq("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: single op from slot 0, 5 - 3 = 2
    req0_valid = 1'b1;
    res_ready  = 1'b1;
    #1;
    check_eq("t1_req0_ready", 32'(req0_ready), 32'd1);
    check_eq("t1_req1_ready", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    check_eq("t1_res_valid", 32'(res_valid), 32'd1);
    check_eq("t1_res_result", res_result, 32'd2);
    check_eq("t1_res_tag", 32'(res_tag), 32'd7);
    check_eq("t1_res_src", 32'(res_src), 32'd0);
    check_eq("t1_res_zero", 32'(res_zero), 32'd0);
    check_eq("t1_grant_cnt0", 32'(grant_cnt0), 32'd1);
    step();
    check_eq("t1_drained", 32'(res_valid), 32'd0);

    // 2: contention from prio=0 alternates 0,1,0,1
    apply_reset();
    req0_a = 32'd10; req0_b = 32'd1; req0_ctrl = 4'd0; req0_tag = 5'd1;  // 11
    req1_a = 32'd20; req1_b = 32'd4; req1_ctrl = 4'd1; req1_tag = 5'd2;  // 16
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    res_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t2_req0_ready", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("t2_req1_ready", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      check_eq("t2_res_src", 32'(res_src), (i % 2 == 1) ? 32'd1 : 32'd0);
      check_eq("t2_res_result", res_result, (i % 2 == 1) ? 32'd16 : 32'd11);
      check_eq("t2_res_tag", 32'(res_tag), (i % 2 == 1) ? 32'd2 : 32'd1);
    end
    check_eq("t2_conflict_cnt", 32'(conflict_cnt), 32'd4);
    check_eq("t2_grant_cnt0", 32'(grant_cnt0), 32'd2);
    check_eq("t2_grant_cnt1", 32'(grant_cnt1), 32'd2);

    // 3: backpressure holds entry, then drain and accept together
    res_ready = 1'b0;
    #1;
    check_eq("t3_bp_req0_ready", 32'(req0_ready), 32'd0);
    check_eq("t3_bp_req1_ready", 32'(req1_ready), 32'd0);
    step();
    check_eq("t3_hold_valid", 32'(res_valid), 32'd1);
    check_eq("t3_hold_result", res_result, 32'd16);
    check_eq("t3_hold_src", 32'(res_src), 32'd1);
    check_eq("t3_hold_conflict", 32'(conflict_cnt), 32'd4);
    res_ready = 1'b1;
    #1;
    check_eq("t3_req0_ready", 32'(req0_ready), 32'd1);
    step();
    check_eq("t3_new_valid", 32'(res_valid), 32'd1);
    check_eq("t3_new_src", 32'(res_src), 32'd0);
    check_eq("t3_new_result", res_result, 32'd11);
    check_eq("t3_grant_cnt0", 32'(grant_cnt0), 32'd3);
    check_eq("t3_conflict_cnt", 32'(conflict_cnt), 32'd5);

    // 4: flush with held entry and slot 1 valid
    req0_valid = 1'b0;
    flush      = 1'b1;
    #1;
    check_eq("t4_req1_ready", 32'(req1_ready), 32'd0);
    step();
    flush      = 1'b0;
    req1_valid = 1'b0;
    check_eq("t4_res_valid", 32'(res_valid), 32'd0);
    check_eq("t4_grant_cnt1", 32'(grant_cnt1), 32'd2);
    check_eq("t4_grant_cnt0", 32'(grant_cnt0), 32'd3);
    check_eq("t4_conflict_cnt", 32'(conflict_cnt), 32'd5);
    // prio was left at 1 by the last slot-0 win
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_eq("t4_prio_req1", 32'(req1_ready), 32'd1);
    check_eq("t4_prio_req0", 32'(req0_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("t4_grant_cnt1_after", 32'(grant_cnt1), 32'd3);

    // 5: saturation at 15 and clear priority
    apply_reset();
    req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 4'd1; req0_tag = 5'd7;
    req0_valid = 1'b1;
    res_ready  = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check_eq("t5_cnt_15", 32'(grant_cnt0), 32'd15);
    step();
    check_eq("t5_cnt_sat", 32'(grant_cnt0), 32'd15);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check_eq("t5_clr", 32'(grant_cnt0), 32'd0);
    check_eq("t5_clr_valid", 32'(res_valid), 32'd1);
    step();
    check_eq("t5_after_clr", 32'(grant_cnt0), 32'd1);

    // 6: asynchronous reset between edges with an op in flight
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_res_valid", 32'(res_valid), 32'd0);
    check_eq("t6_res_result", res_result, 32'd0);
    check_eq("t6_grant_cnt0", 32'(grant_cnt0), 32'd0);
    req1_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("t6_prio_req0", 32'(req0_ready), 32'd1);
    check_eq("t6_prio_req1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("t6_first_src", 32'(res_src), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
